// File: rtl/mbc_power_seq.sv
// Always-on power sequencer for the MBUS Bus Controller domain: orders isolation,
// domain reset and header gating on power-down and power-up, with request queuing.
module mbc_power_seq #(
  parameter int ISO_DLY = 2,
  parameter int PWR_DLY = 4,
  parameter int RST_DLY = 2,
  parameter int CNT_W   = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SLEEP_REQ,
  input  logic WAKEUP_REQ,
  output logic MBC_SLEEP,
  output logic MBC_ISOLATE,
  output logic MBC_RESET,
  output logic MBC_AWAKE,
  output logic BUSY
);

  typedef enum logic [2:0] {
    AWAKE   = 3'd0,
    ISO_ON  = 3'd1,
    RST_ON  = 3'd2,
    ASLEEP  = 3'd3,
    PWR_UP  = 3'd4,
    RST_OFF = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_DLY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wakePend_q, wakePend_d;
  logic             sleepPend_q, sleepPend_d;
  logic             mbcSleep_q, mbcIsolate_q, mbcReset_q, mbcAwake_q, busy_q;
  logic             sleepEff;

  // A simultaneous wake request always overrides a sleep request.
  assign sleepEff = SLEEP_REQ & ~WAKEUP_REQ;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wakePend_d  = wakePend_q;
    sleepPend_d = sleepPend_q;
    case (state_q)
      AWAKE: begin
        if (sleepEff || sleepPend_q) begin
          state_d     = ISO_ON;
          cnt_d       = ISO_LOAD;
          wakePend_d  = 1'b0;
          sleepPend_d = 1'b0;
        end
      end
      ISO_ON, RST_ON: begin
        if (WAKEUP_REQ) begin
          wakePend_d  = 1'b1;
          sleepPend_d = 1'b0;
        end else if (sleepEff) begin
          wakePend_d = 1'b0;
        end
        if (state_q == RST_ON) begin
          state_d = ASLEEP;
        end else if (cnt_q == '0) begin
          state_d = RST_ON;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ASLEEP: begin
        if (WAKEUP_REQ || wakePend_q) begin
          state_d     = PWR_UP;
          cnt_d       = PWR_LOAD;
          wakePend_d  = 1'b0;
          sleepPend_d = 1'b0;
        end
      end
      PWR_UP, RST_OFF: begin
        if (sleepEff) begin
          sleepPend_d = 1'b1;
          wakePend_d  = 1'b0;
        end else if (WAKEUP_REQ) begin
          sleepPend_d = 1'b0;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == PWR_UP) begin
          state_d = RST_OFF;
          cnt_d   = RST_LOAD;
        end else begin
          state_d = AWAKE;
        end
      end
      default: begin
        state_d = ASLEEP;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ASLEEP;
      cnt_q        <= '0;
      wakePend_q   <= 1'b0;
      sleepPend_q  <= 1'b0;
      mbcSleep_q   <= 1'b1;
      mbcIsolate_q <= 1'b1;
      mbcReset_q   <= 1'b1;
      mbcAwake_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wakePend_q   <= wakePend_d;
      sleepPend_q  <= sleepPend_d;
      mbcSleep_q   <= (state_d == ASLEEP);
      mbcIsolate_q <= (state_d != AWAKE);
      mbcReset_q   <= (state_d == RST_ON) || (state_d == ASLEEP) || (state_d == PWR_UP);
      mbcAwake_q   <= (state_d == AWAKE);
      busy_q       <= (state_d != AWAKE) && (state_d != ASLEEP);
    end
  end

  assign MBC_SLEEP   = mbcSleep_q;
  assign MBC_ISOLATE = mbcIsolate_q;
  assign MBC_RESET   = mbcReset_q;
  assign MBC_AWAKE   = mbcAwake_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_mbc_power_seq.sv
// Bench for mbc_power_seq: directed latency scenarios plus random requests checked
// against a timeline model, on a default instance and a minimum-delay instance.
module tb_mbc_power_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, sleepReq, wakeReq;
  logic slp0, iso0, rst0, awk0, bsy0;
  logic slp1, iso1, rst1, awk1, bsy1;
  logic [4:0] dv0, dv1;
  assign dv0 = {slp0, iso0, rst0, awk0, bsy0};
  assign dv1 = {slp1, iso1, rst1, awk1, bsy1};

  mbc_power_seq dut0 (
    .CLK(clock), .RESET(reset), .SLEEP_REQ(sleepReq), .WAKEUP_REQ(wakeReq),
    .MBC_SLEEP(slp0), .MBC_ISOLATE(iso0), .MBC_RESET(rst0), .MBC_AWAKE(awk0), .BUSY(bsy0)
  );

  mbc_power_seq #(.ISO_DLY(1), .PWR_DLY(1), .RST_DLY(1), .CNT_W(8)) dut1 (
    .CLK(clock), .RESET(reset), .SLEEP_REQ(sleepReq), .WAKEUP_REQ(wakeReq),
    .MBC_SLEEP(slp1), .MBC_ISOLATE(iso1), .MBC_RESET(rst1), .MBC_AWAKE(awk1), .BUSY(bsy1)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit monOn = 1'b0;

  // Timeline model: each instance remembers when its last sequence started and in which direction.
  int mIso[2]   = '{2, 1};
  int mPwr[2]   = '{4, 1};
  int mRst[2]   = '{2, 1};
  int mStart[2] = '{-100000, -100000};
  bit mUp[2]    = '{1'b0, 1'b0};
  bit mRev[2]   = '{1'b0, 1'b0};

  // Returns {SLEEP, ISOLATE, RESET} at edge c from the latency rules.
  function automatic logic [2:0] modelOut(int i, int c);
    int e;
    e = c - mStart[i];
    if (mUp[i]) begin
      if (e < mPwr[i]) return 3'b011;
      if (e < mPwr[i] + mRst[i]) return 3'b010;
      return 3'b000;
    end
    if (e < mIso[i]) return 3'b010;
    if (e == mIso[i]) return 3'b011;
    return 3'b111;
  endfunction

  function automatic logic [4:0] expVec(int i);
    logic [2:0] o;
    o = modelOut(i, cyc);
    return {o, o == 3'b000, (o != 3'b000) && (o != 3'b111)};
  endfunction

  task automatic modelStep(int i);
    logic [2:0] prev;
    prev = modelOut(i, cyc - 1);
    if (reset) begin
      mStart[i] = cyc - 1000;
      mUp[i]    = 1'b0;
      mRev[i]   = 1'b0;
    end else if (prev == 3'b111) begin
      if (wakeReq || mRev[i]) begin
        mStart[i] = cyc; mUp[i] = 1'b1; mRev[i] = 1'b0;
      end
    end else if (prev == 3'b000) begin
      if ((sleepReq && !wakeReq) || mRev[i]) begin
        mStart[i] = cyc; mUp[i] = 1'b0; mRev[i] = 1'b0;
      end
    end else if (wakeReq) begin
      mRev[i] = !mUp[i];
    end else if (sleepReq) begin
      mRev[i] = mUp[i];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    modelStep(0);
    modelStep(1);
    @(negedge clock);
  endtask

  // Structural invariants on both instances, every cycle once out of reset.
  always @(negedge clock) begin
    if (monOn) begin
      checks++;
      if ((slp0 && !(iso0 && rst0)) || (!iso0 && (rst0 || slp0)) || (bsy0 !== (iso0 && !slp0)))
        $display("[TB] FAIL invariant0 cyc=%0d got %b", cyc, dv0);
      else passes++;
      checks++;
      if ((slp1 && !(iso1 && rst1)) || (!iso1 && (rst1 || slp1)) || (bsy1 !== (iso1 && !slp1)))
        $display("[TB] FAIL invariant1 cyc=%0d got %b", cyc, dv1);
      else passes++;
    end
  end

  task automatic test_reset();
    reset = 1'b1; sleepReq = 1'b0; wakeReq = 1'b0;
    tick();
    tick();
    checks++;
    if (dv0 !== 5'b11100) $display("[TB] FAIL reset0 got %b want %b", dv0, 5'b11100);
    else passes++;
    checks++;
    if (dv1 !== 5'b11100) $display("[TB] FAIL reset1 got %b want %b", dv1, 5'b11100);
    else passes++;
    reset = 1'b0;
    monOn = 1'b1;
  endtask

  task automatic test_power_up();
    logic [4:0] exp;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (dv0 !== 5'b11100) $display("[TB] FAIL idleAsleep t=%0d got %b want %b", t, dv0, 5'b11100);
      else passes++;
    end
    wakeReq = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      wakeReq = 1'b0;
      exp = {1'b0, t < 6, t < 4, t >= 6, t < 6};
      checks++;
      if (dv0 !== exp) $display("[TB] FAIL powerUp t=%0d got %b want %b", t, dv0, exp);
      else passes++;
      checks++;
      if (dv1 !== expVec(1)) $display("[TB] FAIL powerUpFast t=%0d got %b want %b", t, dv1, expVec(1));
      else passes++;
    end
  endtask

  task automatic test_power_down();
    logic [4:0] exp;
    sleepReq = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      sleepReq = 1'b0;
      exp = {t >= 3, 1'b1, t >= 2, 1'b0, t < 3};
      checks++;
      if (dv0 !== exp) $display("[TB] FAIL powerDown t=%0d got %b want %b", t, dv0, exp);
      else passes++;
      checks++;
      if (dv1 !== expVec(1)) $display("[TB] FAIL powerDownFast t=%0d got %b want %b", t, dv1, expVec(1));
      else passes++;
    end
  endtask

  task automatic test_reversal();
    logic [4:0] exp;
    wakeReq = 1'b1;
    tick();
    wakeReq = 1'b0;
    repeat (7) tick();
    checks++;
    if (dv0 !== 5'b00010) $display("[TB] FAIL reversalStart got %b want %b", dv0, 5'b00010);
    else passes++;
    for (int t = 0; t < 12; t++) begin
      sleepReq = (t == 0);
      wakeReq  = (t == 1);
      tick();
      if (t < 2)       exp = 5'b01001;
      else if (t == 2) exp = 5'b01101;
      else if (t == 3) exp = 5'b11100;
      else if (t < 8)  exp = 5'b01101;
      else if (t < 10) exp = 5'b01001;
      else             exp = 5'b00010;
      checks++;
      if (dv0 !== exp) $display("[TB] FAIL reversal t=%0d got %b want %b", t, dv0, exp);
      else passes++;
      checks++;
      if (dv1 !== expVec(1)) $display("[TB] FAIL reversalFast t=%0d got %b want %b", t, dv1, expVec(1));
      else passes++;
    end
    sleepReq = 1'b0; wakeReq = 1'b0;
  endtask

  task automatic test_simultaneous();
    sleepReq = 1'b1; wakeReq = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      sleepReq = 1'b0; wakeReq = 1'b0;
      checks++;
      if (dv0 !== 5'b00010) $display("[TB] FAIL bothInAwake t=%0d got %b want %b", t, dv0, 5'b00010);
      else passes++;
    end
    sleepReq = 1'b1;
    tick();
    sleepReq = 1'b0;
    repeat (3) tick();
    checks++;
    if (dv0 !== 5'b11100) $display("[TB] FAIL bothPrepAsleep got %b want %b", dv0, 5'b11100);
    else passes++;
    sleepReq = 1'b1; wakeReq = 1'b1;
    tick();
    sleepReq = 1'b0; wakeReq = 1'b0;
    checks++;
    if (dv0 !== 5'b01101) $display("[TB] FAIL bothInAsleep got %b want %b", dv0, 5'b01101);
    else passes++;
    checks++;
    if (dv1 !== expVec(1)) $display("[TB] FAIL bothInAsleepFast got %b want %b", dv1, expVec(1));
    else passes++;
    repeat (6) tick();
    checks++;
    if (dv0 !== 5'b00010) $display("[TB] FAIL bothThenAwake got %b want %b", dv0, 5'b00010);
    else passes++;
  endtask

  task automatic test_reset_midway();
    logic [4:0] exp;
    sleepReq = 1'b1;
    tick();
    sleepReq = 1'b0;
    repeat (3) tick();
    wakeReq = 1'b1;
    tick();
    wakeReq = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (dv0 !== 5'b11100) $display("[TB] FAIL midReset got %b want %b", dv0, 5'b11100);
    else passes++;
    tick();
    checks++;
    if (dv0 !== 5'b11100) $display("[TB] FAIL midResetHold got %b want %b", dv0, 5'b11100);
    else passes++;
    wakeReq = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      wakeReq = 1'b0;
      exp = {1'b0, t < 6, t < 4, t >= 6, t < 6};
      checks++;
      if (dv0 !== exp) $display("[TB] FAIL afterReset t=%0d got %b want %b", t, dv0, exp);
      else passes++;
    end
  endtask

  task automatic test_fast_params();
    logic [4:0] exp;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wakeReq = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      wakeReq = 1'b0;
      exp = (t == 0) ? 5'b01101 : (t == 1) ? 5'b01001 : 5'b00010;
      checks++;
      if (dv1 !== exp) $display("[TB] FAIL fastUp t=%0d got %b want %b", t, dv1, exp);
      else passes++;
    end
    sleepReq = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      sleepReq = 1'b0;
      exp = (t == 0) ? 5'b01001 : (t == 1) ? 5'b01101 : 5'b11100;
      checks++;
      if (dv1 !== exp) $display("[TB] FAIL fastDown t=%0d got %b want %b", t, dv1, exp);
      else passes++;
      checks++;
      if (dv0 !== expVec(0)) $display("[TB] FAIL fastDownRef0 t=%0d got %b want %b", t, dv0, expVec(0));
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 149) == 0);
      sleepReq = ($urandom_range(0, 4) == 0);
      wakeReq  = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (dv0 !== expVec(0)) $display("[TB] FAIL random0 n=%0d got %b want %b", n, dv0, expVec(0));
      else passes++;
      checks++;
      if (dv1 !== expVec(1)) $display("[TB] FAIL random1 n=%0d got %b want %b", n, dv1, expVec(1));
      else passes++;
    end
    reset = 1'b0; sleepReq = 1'b0; wakeReq = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sleepReq = 1'b0; wakeReq = 1'b0;
    @(negedge clock);
    test_reset();
    test_power_up();
    test_power_down();
    test_reversal();
    test_simultaneous();
    test_reset_midway();
    test_fast_params();
    test_random();
    monOn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
